// File: rtl/ahb_lite_single_master.sv
// AHB-Lite single-transfer initiator: local valid/ready commands -> NONSEQ word transfers.
// Optional macro AHB_PIPELINE_EN overlaps the next address phase with the current data phase.
module ahb_lite_single_master #(
    parameter logic [31:0] RESET_HADDR = 32'h0000_0000,
    parameter int          WAIT_CNT_W  = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [WAIT_CNT_W-1:0] rsp_waits,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic                  busy
);

`ifdef AHB_PIPELINE_EN
    localparam logic PIPE_EN = 1'b1;
`else
    localparam logic PIPE_EN = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_ZERO = {WAIT_CNT_W{1'b0}};
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = {WAIT_CNT_W{1'b1}};
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    state_e                  state_q,     state_d;
    logic                    pend_q,      pend_d;
    logic [31:0]             haddr_q,     haddr_d;
    logic                    hwrite_q,    hwrite_d;
    logic [31:0]             awdata_q,    awdata_d;
    logic                    dwrite_q,    dwrite_d;
    logic [31:0]             hwdata_q,    hwdata_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [WAIT_CNT_W-1:0]   rsp_waits_q, rsp_waits_d;

    logic cmd_ready_s;
    logic accept_s;
    logic addr_phase_s;
    logic cancel_s;

    // Handshake and address-phase qualification
    always_comb begin
        // The address slot is free, or the address on the bus is being taken this cycle
        cmd_ready_s  = (state_q == ST_IDLE) ||
                       (PIPE_EN && (state_q != ST_IDLE) && HREADY && !HRESP);
        accept_s     = cmd_valid && cmd_ready_s;
        addr_phase_s = (state_q == ST_ADDR) || pend_q;
        // Any ERROR cycle in our data phase withdraws a pipelined address
        cancel_s     = (state_q == ST_DATA) && HRESP;
    end

    // Next-state and next-register computation
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        awdata_d    = awdata_q;
        dwrite_d    = dwrite_q;
        hwdata_d    = hwdata_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_waits_d = rsp_waits_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d    = ST_DATA;
                    dwrite_d   = hwrite_q;
                    hwdata_d   = hwrite_q ? awdata_q : 32'h0000_0000;
                    wait_cnt_d = WAIT_ZERO;
                    pend_d     = accept_s;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = dwrite_q;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!dwrite_q && !HRESP) ? HRDATA : 32'h0000_0000;
                    rsp_waits_d = wait_cnt_q;
                    if (pend_q && !HRESP) begin
                        state_d    = ST_DATA;
                        dwrite_d   = hwrite_q;
                        hwdata_d   = hwrite_q ? awdata_q : 32'h0000_0000;
                        wait_cnt_d = WAIT_ZERO;
                        pend_d     = accept_s;
                    end else if (pend_q) begin
                        // Cancelled address is still in the slot; re-issue it next cycle
                        state_d  = ST_ADDR;
                        pend_d   = 1'b0;
                        hwdata_d = 32'h0000_0000;
                    end else if (accept_s) begin
                        state_d  = ST_ADDR;
                        hwdata_d = 32'h0000_0000;
                    end else begin
                        state_d  = ST_IDLE;
                        hwdata_d = 32'h0000_0000;
                    end
                end else begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase

        if (accept_s) begin
            haddr_d  = cmd_addr & 32'hFFFF_FFFC;
            hwrite_d = cmd_write;
            awdata_d = cmd_wdata;
        end else if (state_d == ST_IDLE) begin
            haddr_d  = RESET_HADDR;
            hwrite_d = 1'b0;
        end else begin
            haddr_d  = haddr_q;
            hwrite_d = hwrite_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            haddr_q     <= RESET_HADDR;
            hwrite_q    <= 1'b0;
            awdata_q    <= 32'h0000_0000;
            dwrite_q    <= 1'b0;
            hwdata_q    <= 32'h0000_0000;
            wait_cnt_q  <= WAIT_ZERO;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_waits_q <= WAIT_ZERO;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            awdata_q    <= awdata_d;
            dwrite_q    <= dwrite_d;
            hwdata_q    <= hwdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_waits_q <= rsp_waits_d;
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign HTRANS    = (addr_phase_s && !cancel_s) ? 2'b10 : 2'b00;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b010;
    assign HWDATA    = hwdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_waits = rsp_waits_q;

endmodule

// File: doc/ahb_lite_single_master.md
Name: ahb_lite_single_master

Overview:
- AHB-Lite initiator that turns single read/write commands from a local valid/ready interface into AHB-Lite single (NONSEQ, non-burst) word transfers.
- It is the counterpart to the bus-slave peripherals in the subsystem, e.g. the GPIO block at 0x5300_0000 (data) and 0x5300_0004 (direction).
- Used by the test sequencer and boot controller to configure and poll peripherals without a CPU.

Parameters:
- RESET_HADDR, 32'h0000_0000, value driven on HADDR while idle and after reset.
- WAIT_CNT_W, 8, width of the saturating wait-state counter for the last transfer.

Ports:
- HCLK  input  1  bus clock; all logic is on the rising edge.
- HRESET  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the command is accepted on the cycle where cmd_valid and cmd_ready are both high.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  word address; bits [1:0] are ignored and driven as 0.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle completion pulse; there is no backpressure.
- rsp_write  output  1  direction of the completed transfer.
- rsp_err  output  1  the transfer ended with an ERROR response.
- rsp_rdata  output  32  read data; 0 for writes and for errored transfers.
- rsp_waits  output  WAIT_CNT_W  number of data-phase cycles with HREADY=0, saturating.
- HADDR  output  32  bus address.
- HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HWRITE  output  1  bus direction.
- HSIZE  output  3  constant 3'b010 (word).
- HWDATA  output  32  data-phase write data.
- HRDATA  input  32  read data from the slave mux.
- HREADY  input  1  transfer-done / ready from the slave mux.
- HRESP  input  1  0 = OKAY, 1 = ERROR.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, HCLK; reset is synchronous and active-high on HRESET.
- Reset values: HTRANS=IDLE, HADDR=RESET_HADDR, HWRITE=0, HWDATA=0, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0, rsp_waits=0, busy=0.
- Reset in the middle of a transfer drops the transfer: no rsp_valid is produced, and HTRANS is IDLE on the cycle after reset is asserted.
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - cmd_ready=1.
  - On accept, register the command and go to ADDR.
- ADDR:
  - Drive HTRANS=NONSEQ, HADDR={cmd_addr[31:2],2'b00}, HWRITE; cmd_ready=0.
  - HREADY=1: go to DATA.
  - HREADY=0 (previous owner still stalling): hold all address-phase signals stable.
- DATA:
  - HTRANS=IDLE; HWDATA holds the command data for the whole data phase.
  - Each cycle with HREADY=0 increments the wait counter, saturating at all-ones.
  - HREADY=1 and HRESP=0: next cycle rsp_valid=1 with rsp_rdata = HRDATA sampled (reads), rsp_err=0; return to IDLE.
  - HRESP=1 and HREADY=0 (first ERROR cycle): HTRANS stays IDLE; keep waiting.
  - HRESP=1 and HREADY=1 (second ERROR cycle): complete with rsp_err=1 and rsp_rdata=0.
- Latency with zero wait states:
  - Command accepted in cycle N.
  - NONSEQ address phase in cycle N+1.
  - Data phase in N+2.
  - rsp_valid in N+3.
  - Next command accepted in N+3.
- rsp_* outputs hold their value until the next completion; only rsp_valid is a pulse.
- HWDATA is 0 during read data phases.
- cmd_valid is ignored while cmd_ready=0; the source must hold the command until accepted.

Optional Feature:
- Macro: AHB_PIPELINE_EN.
- Defined:
  - cmd_ready is also 1 in DATA whenever HREADY=1 and HRESP=0.
  - An accepted command drives its NONSEQ address phase in the next cycle, overlapping the current data phase; back-to-back zero-wait transfers complete one per cycle.
  - If the current data phase returns the first ERROR cycle while a pipelined address phase is pending, HTRANS is forced to IDLE in that cycle.
  - The pending command is retained and re-issued as NONSEQ after the error completes. It is never dropped or duplicated.
- Undefined: behaviour is exactly as above, with cmd_ready only in IDLE.

Test Plan:
- Write 0x5300_0004 data 0x1, then write 0x5300_0000 data 0xA5A5 with zero waits -> NONSEQ in N+1, HWDATA=0x0000_0001 then 0x0000_A5A5 in the data phases; rsp_valid at N+3, rsp_err=0, rsp_waits=0.
- Read 0x5300_0000, slave returns HRDATA=0x0000_A5A5 after 3 HREADY=0 cycles -> rsp_rdata=0x0000_A5A5, rsp_waits=3, HADDR/HWRITE stable, HTRANS=IDLE during the waits.
- Write 0x5300_0008 with slave ERROR (HRESP=1/HREADY=0 then HRESP=1/HREADY=1) -> rsp_err=1, rsp_rdata=0, FSM back in IDLE, cmd_ready=1.
- HRESET asserted during the DATA state of a read -> no rsp_valid; next cycle HTRANS=IDLE, HADDR=RESET_HADDR, busy=0.
- cmd_addr=0x5300_0003 -> HADDR=0x5300_0000; HSIZE=3'b010 on every cycle.
- With AHB_PIPELINE_EN, 4 back-to-back writes with zero waits -> 4 consecutive NONSEQ cycles and 4 consecutive rsp_valid pulses.
- With AHB_PIPELINE_EN, ERROR on write 2 -> write 3 is re-issued after the error completes, and exactly 4 responses are produced.
